// File: rtl/sram_like_pkg.sv
// Shared types, constants and helpers for the sram-like channel arbiter.
package sram_like_pkg;

    localparam int unsigned DATA_W = 32;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_state_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of channel IDs for requests whose address phase has been accepted.
module sram_like_id_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int unsigned PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int unsigned CW = clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges masters onto one slave port and routes
// in-order responses back to the issuing channel via an ID FIFO.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        m_req,
    input  logic [NUM_CH-1:0]        m_wr,
    input  logic [2*NUM_CH-1:0]      m_size,
    input  logic [4*NUM_CH-1:0]      m_wstrb,
    input  logic [32*NUM_CH-1:0]     m_addr,
    input  logic [32*NUM_CH-1:0]     m_wdata,
    output logic [NUM_CH-1:0]        m_addr_ok,
    output logic [NUM_CH-1:0]        m_data_ok,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [DATA_W-1:0]        s_rdata,
    output logic [clog2(MAX_OUT):0]  outstanding,
    output logic                     err_spurious
);

    localparam int unsigned ID_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    lock_state_e     state, state_n;
    logic [ID_W-1:0] lock_ch;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] head;
    logic            any;
    logic            accept;
    logic            pop;
    logic            full;
    logic            empty;
    int unsigned     idx;

    // Grant selection: a held lock wins outright, otherwise fixed or round-robin search.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        cand  = '0;
        if (state == LOCK_HELD) begin
            grant = lock_ch;
            any   = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                idx = (ARB_MODE == ARB_RR) ? (int'(rr_ptr) + i) : i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                cand = ID_W'(idx);
                if (!any && m_req[cand]) begin
                    any   = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    assign s_req  = !reset && !full && any;
    assign accept = s_req && s_addr_ok;
    assign pop    = s_data_ok && !empty;

    // Slave-side request fields follow the granted channel combinationally.
    always_comb begin
        s_wr    = m_wr[grant];
        s_size  = m_size[int'(grant)*2 +: 2];
        s_wstrb = m_wstrb[int'(grant)*4 +: 4];
        s_addr  = m_addr[int'(grant)*32 +: 32];
        s_wdata = m_wdata[int'(grant)*32 +: 32];
    end

    assign m_addr_ok = accept ? (NUM_CH'(1) << grant) : '0;
    assign m_data_ok = (pop && !reset) ? (NUM_CH'(1) << head) : '0;
    assign m_rdata   = s_rdata;

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOCK_IDLE;
        else       state <= state_n;
    end

    // Lock next-state: an unaccepted request freezes the grant until the slave accepts it.
    always_comb begin
        state_n = state;
        case (state)
            LOCK_IDLE: if (s_req && !s_addr_ok) state_n = LOCK_HELD;
            LOCK_HELD: if (s_addr_ok)           state_n = LOCK_IDLE;
            default:                            state_n = LOCK_IDLE;
        endcase
    end

    // Locked channel capture and round-robin pointer advance past the accepted channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_ch <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == LOCK_IDLE && s_req && !s_addr_ok) lock_ch <= grant;
            if (ARB_MODE == ARB_RR && accept)
                rr_ptr <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);
        end
    end

    // Sticky flag for a slave response with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     err_spurious <= 1'b0;
        else if (s_data_ok && empty)   err_spurious <= 1'b1;
    end

    sram_like_id_fifo #(
        .DEPTH (MAX_OUT),
        .W     (ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (grant),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are checked against a queue-based reference model each cycle.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_wr = '0;
    logic [3:0]  m_size = '0;
    logic [7:0]  m_wstrb = '0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic        s_addr_ok = 1'b0;
    logic        s_data_ok = 1'b0;
    logic [31:0] s_rdata = '0;

    logic [1:0]  o_aok    [2];
    logic [1:0]  o_dok    [2];
    logic [31:0] o_rdata  [2];
    logic        o_sreq   [2];
    logic        o_swr    [2];
    logic [1:0]  o_ssize  [2];
    logic [3:0]  o_swstrb [2];
    logic [31:0] o_saddr  [2];
    logic [31:0] o_swdata [2];
    logic [2:0]  o_out    [2];
    logic        o_err    [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance (0 = round-robin, 1 = fixed).
    int mq [0:1][$];
    bit mlk   [2];
    int mlkch [2];
    int mrr;
    bit merr  [2];
    bit pending;
    bit e_sreq [2];
    bit e_acc  [2];
    bit e_pop  [2];
    bit e_spur [2];
    bit e_lock [2];
    int e_g    [2];

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_CH(2), .MAX_OUT(4), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(o_aok[0]), .m_data_ok(o_dok[0]), .m_rdata(o_rdata[0]),
        .s_req(o_sreq[0]), .s_wr(o_swr[0]), .s_size(o_ssize[0]), .s_wstrb(o_swstrb[0]),
        .s_addr(o_saddr[0]), .s_wdata(o_swdata[0]), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outstanding(o_out[0]),
        .err_spurious(o_err[0])
    );

    sram_like_arbiter #(.NUM_CH(2), .MAX_OUT(4), .ARB_MODE(0)) u_fx (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(o_aok[1]), .m_data_ok(o_dok[1]), .m_rdata(o_rdata[1]),
        .s_req(o_sreq[1]), .s_wr(o_swr[1]), .s_size(o_ssize[1]), .s_wstrb(o_swstrb[1]),
        .s_addr(o_saddr[1]), .s_wdata(o_swdata[1]), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outstanding(o_out[1]),
        .err_spurious(o_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic string tag(input int k, input string s);
        return {(k == 0) ? "rr." : "fx.", s};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mlk[k]   = 1'b0;
            mlkch[k] = 0;
            merr[k]  = 1'b0;
        end
        mrr     = 0;
        pending = 1'b0;
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            if (e_pop[k])  void'(mq[k].pop_front());
            if (e_acc[k])  mq[k].push_back(e_g[k]);
            if (e_spur[k]) merr[k] = 1'b1;
            mlk[k]   = e_lock[k];
            mlkch[k] = e_g[k];
            if (k == 0 && e_acc[k]) mrr = (e_g[k] + 1) % 2;
        end
        pending = 1'b0;
    endtask

    // One cycle: drive at the falling edge, then predict and compare settled outputs.
    task automatic step(input logic [1:0] req, input logic aok, input logic dok,
                        input logic [31:0] rdata, input logic [31:0] a0, input logic [31:0] a1);
        int sz;
        int c;
        logic [31:0] exp_dok;
        @(negedge clk);
        if (pending) model_commit();
        m_req     = req;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rdata;
        m_addr    = {a1, a0};
        m_wdata   = {$urandom, $urandom};
        m_wr      = 2'($urandom);
        m_size    = 4'($urandom);
        m_wstrb   = 8'($urandom);
        #1;
        for (int k = 0; k < 2; k++) begin
            sz = mq[k].size();
            e_sreq[k] = 1'b0;
            e_g[k]    = 0;
            if (sz < 4) begin
                if (mlk[k]) begin
                    e_sreq[k] = 1'b1;
                    e_g[k]    = mlkch[k];
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        c = (k == 0) ? (mrr + i) % 2 : i;
                        if (!e_sreq[k] && req[c]) begin
                            e_sreq[k] = 1'b1;
                            e_g[k]    = c;
                        end
                    end
                end
            end
            e_acc[k]  = e_sreq[k] && aok;
            e_lock[k] = e_sreq[k] && !aok;
            e_pop[k]  = dok && sz > 0;
            e_spur[k] = dok && sz == 0;
            check(tag(k, "s_req"), 32'(o_sreq[k]), 32'(e_sreq[k]));
            if (e_sreq[k]) begin
                check(tag(k, "s_addr"), o_saddr[k], m_addr[e_g[k]*32 +: 32]);
                check(tag(k, "s_wdata"), o_swdata[k], m_wdata[e_g[k]*32 +: 32]);
                check(tag(k, "s_ctl"), {25'd0, o_swr[k], o_ssize[k], o_swstrb[k]},
                      {25'd0, m_wr[e_g[k]], m_size[e_g[k]*2 +: 2], m_wstrb[e_g[k]*4 +: 4]});
            end
            check(tag(k, "m_addr_ok"), 32'(o_aok[k]), e_acc[k] ? (32'd1 << e_g[k]) : 32'd0);
            exp_dok = e_pop[k] ? (32'd1 << mq[k][0]) : 32'd0;
            check(tag(k, "m_data_ok"), 32'(o_dok[k]), exp_dok);
            if (e_pop[k]) check(tag(k, "m_rdata"), o_rdata[k], rdata);
            check(tag(k, "outstanding"), 32'(o_out[k]), 32'(sz));
            check(tag(k, "err_spurious"), 32'(o_err[k]), 32'(merr[k]));
        end
        pending = 1'b1;
    endtask

    task automatic do_reset(input logic [1:0] req, input logic dok);
        @(negedge clk);
        reset     = 1'b1;
        m_req     = req;
        s_addr_ok = 1'b1;
        s_data_ok = dok;
        #1;
        for (int k = 0; k < 2; k++) begin
            check(tag(k, "rst.s_req"), 32'(o_sreq[k]), 32'd0);
            check(tag(k, "rst.m_addr_ok"), 32'(o_aok[k]), 32'd0);
            check(tag(k, "rst.m_data_ok"), 32'(o_dok[k]), 32'd0);
            check(tag(k, "rst.outstanding"), 32'(o_out[k]), 32'd0);
            check(tag(k, "rst.err"), 32'(o_err[k]), 32'd0);
        end
        model_clear();
        @(negedge clk);
        reset     = 1'b0;
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;
        logic       aok;
        logic       dok;
        logic [1:0] aok_rr;
        logic [1:0] aok_fx;
        logic [1:0] dok_rr;
        logic [1:0] dok_fx;
        logic       sreq;
        int         out;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 0};
        tbl[1] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 1'b1, 1};
        tbl[2] = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 1};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 1'b1, 1};
        tbl[4] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 1};
        tbl[5] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0};

        model_clear();
        do_reset(2'b11, 1'b1);

        // Alternating round-robin grants and response routing, fixed priority alongside.
        for (int v = 0; v < 6; v++) begin
            step(tbl[v].req, tbl[v].aok, tbl[v].dok, $urandom, $urandom, $urandom);
            check("tbl.aok_rr", 32'(o_aok[0]), 32'(tbl[v].aok_rr));
            check("tbl.aok_fx", 32'(o_aok[1]), 32'(tbl[v].aok_fx));
            check("tbl.dok_rr", 32'(o_dok[0]), 32'(tbl[v].dok_rr));
            check("tbl.dok_fx", 32'(o_dok[1]), 32'(tbl[v].dok_fx));
            check("tbl.sreq", 32'(o_sreq[0]), 32'(tbl[v].sreq));
            check("tbl.out", 32'(o_out[0]), 32'(tbl[v].out));
        end

        // Fixed priority: ch1 stalled request holds the grant over a later ch0 request.
        do_reset(2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0, 0, 32'h100, 32'h200);
        check("lock.addr0", o_saddr[1], 32'h200);
        step(2'b11, 1'b0, 1'b0, 0, 32'h100, 32'h200);
        check("lock.addr1", o_saddr[1], 32'h200);
        check("lock.aok1", 32'(o_aok[1]), 32'd0);
        step(2'b11, 1'b0, 1'b0, 0, 32'h100, 32'h200);
        check("lock.addr2", o_saddr[1], 32'h200);
        step(2'b11, 1'b1, 1'b0, 0, 32'h100, 32'h200);
        check("lock.accept1", 32'(o_aok[1]), 32'd2);
        step(2'b11, 1'b1, 1'b0, 0, 32'h100, 32'h200);
        check("lock.accept0", 32'(o_aok[1]), 32'd1);
        check("lock.addr_ch0", o_saddr[1], 32'h100);

        // Full FIFO blocks s_req, even with a same-cycle pop.
        do_reset(2'b00, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b01, 1'b1, 1'b0, 0, $urandom, $urandom);
        step(2'b01, 1'b1, 1'b0, 0, $urandom, $urandom);
        check("full.sreq", 32'(o_sreq[0]), 32'd0);
        check("full.out", 32'(o_out[0]), 32'd4);
        step(2'b01, 1'b1, 1'b1, 32'h55, $urandom, $urandom);
        check("full.sreq_pop", 32'(o_sreq[0]), 32'd0);
        check("full.dok", 32'(o_dok[0]), 32'd1);
        step(2'b01, 1'b0, 1'b0, 0, $urandom, $urandom);
        check("full.resume", 32'(o_sreq[0]), 32'd1);
        check("full.out3", 32'(o_out[0]), 32'd3);

        // Spurious response with nothing outstanding is sticky.
        do_reset(2'b00, 1'b0);
        step(2'b00, 1'b0, 1'b1, 32'hDEAD, 0, 0);
        check("spur.dok", 32'(o_dok[0]), 32'd0);
        step(2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("spur.err", 32'(o_err[0]), 32'd1);
        step(2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("spur.sticky", 32'(o_err[1]), 32'd1);

        // Read data routed back in issue order.
        do_reset(2'b00, 1'b0);
        step(2'b01, 1'b1, 1'b0, 0, 32'h1000, 32'h0);
        check("route.addr0", o_saddr[0], 32'h1000);
        step(2'b10, 1'b1, 1'b0, 0, 32'h0, 32'h2000);
        check("route.addr1", o_saddr[0], 32'h2000);
        check("route.aok1", 32'(o_aok[0]), 32'd2);
        step(2'b00, 1'b0, 1'b1, 32'hAAAA, 0, 0);
        check("route.dok0", 32'(o_dok[0]), 32'd1);
        check("route.rdata0", o_rdata[0], 32'hAAAA);
        step(2'b00, 1'b0, 1'b1, 32'hBBBB, 0, 0);
        check("route.dok1", 32'(o_dok[0]), 32'd2);
        check("route.rdata1", o_rdata[0], 32'hBBBB);

        // Reset with three outstanding and a held lock, then a stale response.
        do_reset(2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 0, $urandom, $urandom);
        step(2'b10, 1'b0, 1'b0, 0, $urandom, $urandom);
        check("midrst.out_before", 32'(o_out[0]), 32'd3);
        do_reset(2'b11, 1'b1);
        step(2'b00, 1'b0, 1'b1, 32'h1234, 0, 0);
        check("midrst.dok", 32'(o_dok[0]), 32'd0);
        step(2'b00, 1'b0, 1'b0, 0, 0, 0);
        check("midrst.err", 32'(o_err[0]), 32'd1);

        // Randomized traffic against the reference model.
        do_reset(2'b00, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
                 $urandom, $urandom, $urandom);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
